// File: rtl/wb_stream_mailbox.sv
// Wishbone mailbox: host DATA writes feed a TX stream, RX stream words are popped by host DATA reads.
// STATUS/CONTROL/SCRATCH registers expose fill levels, sticky errors, flushes and the interrupt enable.

module wb_stream_mailbox_fifo #(
    parameter int DEPTH = 16,
    parameter int LW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic [LW:0] level,
    output logic        empty,
    output logic        full
);
    logic [31:0]   mem [DEPTH];
    logic [LW-1:0] wr_ptr_reg;
    logic [LW-1:0] rd_ptr_reg;
    logic [LW:0]   level_reg;
    logic          do_push;
    logic          do_pop;

    assign empty   = (level_reg == '0);
    assign full    = (level_reg == (LW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot that a push into a full FIFO needs.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr_reg];
    assign level   = level_reg;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            level_reg <= level_reg + (LW+1)'(do_push) - (LW+1)'(do_pop);
        end
    end
endmodule

module wb_stream_mailbox #(
    parameter int DEPTH = 16,
    parameter int AW    = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_wb_cyc,
    input  logic          i_wb_stb,
    input  logic          i_wb_we,
    input  logic [AW-1:0] i_wb_adr,
    input  logic [31:0]   i_wb_dat,
    output logic [31:0]   o_wb_dat,
    output logic          o_wb_ack,
    output logic [31:0]   o_tx_data,
    output logic          o_tx_valid,
    input  logic          i_tx_ready,
    input  logic [31:0]   i_rx_data,
    input  logic          i_rx_valid,
    output logic          o_rx_ready,
    output logic          o_irq
);
    localparam int LW = $clog2(DEPTH);
    localparam int TX = 0;
    localparam int RX = 1;
    localparam logic [1:0] ADR_DATA    = 2'd0;
    localparam logic [1:0] ADR_STATUS  = 2'd1;
    localparam logic [1:0] ADR_CTRL    = 2'd2;
    localparam logic [1:0] ADR_SCRATCH = 2'd3;

    logic             ack_reg;
    logic [31:0]      dat_reg;
    logic             irq_reg;
    logic             irq_en_reg;
    logic [31:0]      scratch_reg;
    logic             tx_ovf_reg;
    logic             rx_unf_reg;

    logic [1:0]       fifo_flush, fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [1:0][31:0] fifo_din, fifo_dout;
    logic [1:0][LW:0] fifo_level;

    logic [1:0]       adr;
    logic             req, wr_req, rd_req;
    logic             data_wr, data_rd, ctrl_wr;
    logic             tx_pop, rx_ready;
    logic             tx_ovf_set, rx_unf_set, sticky_clr;
    logic [31:0]      rd_data;
    logic             unused_adr_bits;

    assign adr             = i_wb_adr[1:0];
    assign unused_adr_bits = ^i_wb_adr[AW-1:2];
    // Ack is a one-cycle pulse, so a master holding stb is served every second cycle.
    assign req     = i_wb_cyc & i_wb_stb & ~ack_reg;
    assign wr_req  = req & i_wb_we;
    assign rd_req  = req & ~i_wb_we;
    assign data_wr = wr_req & (adr == ADR_DATA);
    assign data_rd = rd_req & (adr == ADR_DATA);
    assign ctrl_wr = wr_req & (adr == ADR_CTRL);

    assign tx_pop   = ~fifo_empty[TX] & i_tx_ready;
    assign rx_ready = ~fifo_full[RX] & ~rst;

    assign fifo_push[TX]  = data_wr;
    assign fifo_pop[TX]   = tx_pop;
    assign fifo_din[TX]   = i_wb_dat;
    assign fifo_flush[TX] = ctrl_wr & i_wb_dat[0];
    assign fifo_push[RX]  = i_rx_valid & rx_ready;
    assign fifo_pop[RX]   = data_rd;
    assign fifo_din[RX]   = i_rx_data;
    assign fifo_flush[RX] = ctrl_wr & i_wb_dat[1];

    assign tx_ovf_set = data_wr & fifo_full[TX] & ~tx_pop;
    assign rx_unf_set = data_rd & fifo_empty[RX];
    assign sticky_clr = ctrl_wr & i_wb_dat[2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
            wb_stream_mailbox_fifo #(.DEPTH(DEPTH)) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .flush (fifo_flush[gi]),
                .push  (fifo_push[gi]),
                .pop   (fifo_pop[gi]),
                .din   (fifo_din[gi]),
                .dout  (fifo_dout[gi]),
                .level (fifo_level[gi]),
                .empty (fifo_empty[gi]),
                .full  (fifo_full[gi])
            );
        end
    endgenerate

    // STATUS reflects the state before this cycle's updates land.
    always_comb begin
        rd_data = '0;
        case (adr)
            ADR_DATA:   rd_data = fifo_empty[RX] ? '0 : fifo_dout[RX];
            ADR_STATUS: begin
                rd_data[0]     = fifo_empty[TX];
                rd_data[1]     = fifo_full[TX];
                rd_data[2]     = fifo_empty[RX];
                rd_data[3]     = fifo_full[RX];
                rd_data[4]     = tx_ovf_reg;
                rd_data[5]     = rx_unf_reg;
                rd_data[15:8]  = 8'(fifo_level[TX]);
                rd_data[23:16] = 8'(fifo_level[RX]);
            end
            ADR_CTRL:   rd_data[8] = irq_en_reg;
            default:    rd_data = scratch_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_reg     <= 1'b0;
            dat_reg     <= '0;
            irq_reg     <= 1'b0;
            irq_en_reg  <= 1'b0;
            scratch_reg <= '0;
            tx_ovf_reg  <= 1'b0;
            rx_unf_reg  <= 1'b0;
        end else begin
            ack_reg <= req;
            dat_reg <= rd_req ? rd_data : '0;
            irq_reg <= irq_en_reg & ~fifo_empty[RX];
            if (ctrl_wr) irq_en_reg <= i_wb_dat[8];
            if (wr_req && adr == ADR_SCRATCH) scratch_reg <= i_wb_dat;
            // A new error in the clearing cycle keeps its flag set.
            tx_ovf_reg <= tx_ovf_set | (tx_ovf_reg & ~sticky_clr);
            rx_unf_reg <= rx_unf_set | (rx_unf_reg & ~sticky_clr);
        end
    end

    assign o_wb_ack   = ack_reg;
    assign o_wb_dat   = dat_reg;
    assign o_irq      = irq_reg;
    assign o_tx_data  = fifo_dout[TX];
    assign o_tx_valid = ~fifo_empty[TX];
    assign o_rx_ready = rx_ready;
endmodule

// File: tb/tb_wb_stream_mailbox.sv
// Scoreboard bench for wb_stream_mailbox: stimulus queues expected WB reads and TX beats,
// independent monitors compare them as the DUT acks or presents stream beats.

module tb_wb_stream_mailbox;
    localparam int DEPTH = 16;
    localparam int AW    = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_wb_cyc, i_wb_stb, i_wb_we;
    logic [AW-1:0] i_wb_adr;
    logic [31:0]   i_wb_dat;
    logic [31:0]   o_wb_dat;
    logic          o_wb_ack;
    logic [31:0]   o_tx_data;
    logic          o_tx_valid;
    logic          i_tx_ready;
    logic [31:0]   i_rx_data;
    logic          i_rx_valid;
    logic          o_rx_ready;
    logic          o_irq;

    always #5 clk = ~clk;

    wb_stream_mailbox #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_wb_cyc   (i_wb_cyc),
        .i_wb_stb   (i_wb_stb),
        .i_wb_we    (i_wb_we),
        .i_wb_adr   (i_wb_adr),
        .i_wb_dat   (i_wb_dat),
        .o_wb_dat   (o_wb_dat),
        .o_wb_ack   (o_wb_ack),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (i_tx_ready),
        .i_rx_data  (i_rx_data),
        .i_rx_valid (i_rx_valid),
        .o_rx_ready (o_rx_ready),
        .o_irq      (o_irq)
    );

    typedef struct packed {
        logic        is_rd;
        logic [1:0]  adr;
        logic [31:0] exp;
    } wb_exp_t;

    wb_exp_t     wb_q[$];
    logic [31:0] tx_q[$];
    int          checks = 0;
    int          passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endtask

    // WB monitor: every ack consumes one expected entry; reads compare data.
    always @(negedge clk) begin
        if (o_wb_ack) begin
            if (wb_q.size() == 0) begin
                checks++;
                $display("FAIL wb_ack: got an ack, required none (no request outstanding)");
            end else begin
                wb_exp_t e;
                e = wb_q.pop_front();
                if (e.is_rd) begin
                    $display("wb read  adr=%0d data=0x%08h", e.adr, o_wb_dat);
                    check($sformatf("wb_read_adr%0d", e.adr), o_wb_dat, e.exp);
                end else begin
                    $display("wb write adr=%0d acked", e.adr);
                end
            end
        end
    end

    // TX stream monitor: a beat completes on the next edge when valid & ready.
    always @(negedge clk) begin
        if (o_tx_valid && i_tx_ready) begin
            if (tx_q.size() == 0) begin
                checks++;
                $display("FAIL tx_beat: got beat 0x%08h, required none", o_tx_data);
            end else begin
                logic [31:0] exp_w;
                exp_w = tx_q.pop_front();
                $display("tx beat  data=0x%08h", o_tx_data);
                check("tx_beat", o_tx_data, exp_w);
            end
        end
    end

    task automatic wb_xfer(input bit we, input logic [1:0] adr, input logic [31:0] wdat,
                           input logic [31:0] exp, input bit txp, input bit rxp,
                           input logic [31:0] rxd);
        wb_exp_t e;
        e.is_rd = !we;
        e.adr   = adr;
        e.exp   = exp;
        wb_q.push_back(e);
        i_wb_cyc = 1'b1;
        i_wb_stb = 1'b1;
        i_wb_we  = we;
        i_wb_adr = {22'($urandom), adr};
        i_wb_dat = wdat;
        if (txp) i_tx_ready = 1'b1;
        if (rxp) begin
            i_rx_valid = 1'b1;
            i_rx_data  = rxd;
        end
        @(posedge clk); #1;
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        if (txp) i_tx_ready = 1'b0;
        if (rxp) i_rx_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [1:0] adr, input logic [31:0] d);
        wb_xfer(1'b1, adr, d, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic rd(input logic [1:0] adr, input logic [31:0] exp);
        wb_xfer(1'b0, adr, 32'h0, exp, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
        i_wb_adr = '0; i_wb_dat = '0;
        i_tx_ready = 1'b0; i_rx_valid = 1'b0; i_rx_data = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(o_wb_ack), 32'h0);
        check("rst_dat", o_wb_dat, 32'h0);
        check("rst_tx_valid", 32'(o_tx_valid), 32'h0);
        check("rst_irq", 32'(o_irq), 32'h0);
        check("rst_rx_ready", 32'(o_rx_ready), 32'h0);
        rst = 1'b0;
        #1;
        check("rx_ready_after_rst", 32'(o_rx_ready), 32'h1);
        @(posedge clk); #1;

        // TX streaming with ready held high
        i_tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tx_q.push_back(32'h12345678 + 32'(i));
            wr(2'd0, 32'h12345678 + 32'(i));
        end
        rd(2'd1, 32'h0000_0005);

        // Overflow: 17 writes into a 16-deep FIFO with the stream stalled
        i_tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) tx_q.push_back(32'h100 + 32'(i));
            wr(2'd0, 32'h100 + 32'(i));
        end
        rd(2'd1, 32'h0000_1016);
        wr(2'd2, 32'h4);
        rd(2'd1, 32'h0000_1006);

        // Full TX: WB write coincident with a stream pop is accepted
        tx_q.push_back(32'h200);
        wb_xfer(1'b1, 2'd0, 32'h200, 32'h0, 1'b1, 1'b0, 32'h0);
        rd(2'd1, 32'h0000_1006);

        i_tx_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("tx_drained", 32'(tx_q.size()), 32'h0);
        rd(2'd1, 32'h0000_0005);

        // RX stream, interrupt and underflow
        wr(2'd2, 32'h100);
        i_rx_valid = 1'b1; i_rx_data = 32'hA0;
        @(posedge clk); #1;
        i_rx_data = 32'hA1;
        check("irq_one_after_push", 32'(o_irq), 32'h0);
        @(posedge clk); #1;
        i_rx_data = 32'hA2;
        check("irq_two_after_push", 32'(o_irq), 32'h1);
        @(posedge clk); #1;
        i_rx_data = 32'hA3;
        @(posedge clk); #1;
        i_rx_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd(2'd0, 32'hA0 + 32'(i));
            if (i == 2) check("irq_before_last_pop", 32'(o_irq), 32'h1);
            if (i == 3) check("irq_after_last_pop", 32'(o_irq), 32'h0);
        end
        rd(2'd0, 32'h0);
        rd(2'd1, 32'h0000_0025);

        // Flush both FIFOs while a stream push lands in the same cycle
        i_tx_ready = 1'b0;
        wr(2'd0, 32'h300);
        wr(2'd0, 32'h301);
        i_rx_valid = 1'b1; i_rx_data = 32'hB0;
        @(posedge clk); #1;
        i_rx_data = 32'hB1;
        @(posedge clk); #1;
        i_rx_valid = 1'b0;
        rd(2'd1, 32'h0002_0220);
        wb_xfer(1'b1, 2'd2, 32'h107, 32'h0, 1'b0, 1'b1, 32'hB2);
        rd(2'd1, 32'h0000_0005);
        rd(2'd2, 32'h0000_0100);
        check("irq_after_flush", 32'(o_irq), 32'h0);
        wr(2'd2, 32'h0);
        rd(2'd3, 32'h0);
        wr(2'd3, 32'hDEADBEEF);
        rd(2'd3, 32'hDEADBEEF);

        // Reset mid-burst with five TX entries and a read in flight
        for (int i = 0; i < 5; i++) wr(2'd0, 32'h400 + 32'(i));
        rd(2'd1, 32'h0000_0504);
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_adr = 24'h3;
        i_rx_valid = 1'b1; i_rx_data = 32'hC0;
        rst = 1'b1;
        #1;
        check("rx_ready_in_rst", 32'(o_rx_ready), 32'h0);
        @(posedge clk); #1;
        check("midrst_ack", 32'(o_wb_ack), 32'h0);
        check("midrst_dat", o_wb_dat, 32'h0);
        check("midrst_tx_valid", 32'(o_tx_valid), 32'h0);
        check("midrst_irq", 32'(o_irq), 32'h0);
        check("midrst_rx_ready", 32'(o_rx_ready), 32'h0);
        rst = 1'b0;
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_rx_valid = 1'b0;
        #1;
        check("rx_ready_after_midrst", 32'(o_rx_ready), 32'h1);
        @(posedge clk); #1;
        rd(2'd1, 32'h0000_0005);
        rd(2'd3, 32'h0);
        rd(2'd2, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        check("wb_q_empty", 32'(wb_q.size()), 32'h0);
        check("tx_q_empty", 32'(tx_q.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/wb_stream_mailbox.md
# wb_stream_mailbox

Wishbone slave mailbox sitting directly downstream of `wb_spi_slave`: SPI host word writes to the DATA register push 32-bit words into a TX FIFO that drains onto a valid/ready stream toward the SoC fabric. Fabric words arriving on an RX stream fill an RX FIFO that the host pops by reading DATA. STATUS and CONTROL registers give the host fill levels, sticky error flags, flush control and an interrupt enable, so the bridge can move bulk data without a memory behind it.

## Interface
- `DEPTH`, 16: entries per FIFO; power of two, 2..128.
- `AW`, 24: Wishbone address width, matching the bridge.
- `clk` in 1: system clock.
- `rst` in 1: reset; one clock; reset is synchronous and active-high.
- `i_wb_cyc`, `i_wb_stb`, `i_wb_we` in 1: Wishbone cycle, strobe and write enable.
- `i_wb_adr` in AW: word address; only [1:0] decoded, upper bits ignored.
- `i_wb_dat` in 32: write data.
- `o_wb_dat` out 32: read data, registered.
- `o_wb_ack` out 1: acknowledge, registered.
- `o_tx_data` out 32: TX stream data (head of TX FIFO).
- `o_tx_valid` out 1: TX stream valid.
- `i_tx_ready` in 1: TX stream ready.
- `i_rx_data` in 32: RX stream data.
- `i_rx_valid` in 1: RX stream valid.
- `o_rx_ready` out 1: RX stream ready.
- `o_irq` out 1: interrupt to host, registered.

## Operation
- Register map (adr[1:0]):
  - 0 DATA: a write pushes TX; a read pops RX.
  - 1 STATUS, RO:
    - [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full.
    - [4] tx_overflow (sticky), [5] rx_underflow (sticky).
    - [15:8] tx_level, [23:16] rx_level; other bits 0.
  - 2 CONTROL: write bit0 flushes TX, bit1 flushes RX, bit2 clears sticky flags; bit8 is irq_en (R/W). Bits 0-2 self-clear and read 0.
  - 3 SCRATCH: 32-bit R/W, reset 0.
- Request accepted when `i_wb_cyc & i_wb_stb & !o_wb_ack`. A master holding `stb` gets ack every second cycle. Each accepted request has exactly one side effect.
- TX write when full: data dropped, tx_overflow set, still acked.
  - Exception: if the TX stream pops in the same cycle, the push is accepted.
- DATA read when RX empty: returns 0, rx_underflow set, still acked.
  - No bypass: a same-cycle RX stream push does not satisfy the read.
- TX stream: `o_tx_valid = !tx_empty`, first-word fall-through. Pop on `o_tx_valid & i_tx_ready`.
- RX stream: `o_rx_ready = !rx_full & !rst`. Push on `i_rx_valid & o_rx_ready`.
- Flush vs simultaneous push/pop on the same FIFO: flush wins, FIFO empty next cycle.
- Sticky clear vs simultaneous new error: error wins, flag stays set.
- Simultaneous WB push and stream pop on TX (or stream push and WB pop on RX): level unchanged, both happen.
- `o_irq` = registered (irq_en & !rx_empty).
- Pointers wrap modulo DEPTH; levels are log2(DEPTH)+1 bits, zero-extended into STATUS.

## Timing
- Request sampled at edge N:
  - `o_wb_ack` and `o_wb_dat` valid after N, high for one cycle.
  - FIFO/flag/register updates also take effect at N.
- STATUS read returns pre-update state at edge N.
- TX: DATA write at edge N makes `o_tx_valid` high after N (one-cycle latency, no bubble).
- RX: stream push at edge N makes rx_empty clear after N; `o_irq` rises after N+1.
- Full TX FIFO sustains one pop per cycle. Full RX FIFO drops `o_rx_ready` the cycle after the push that fills it.
- Reset values, with `rst` high at an edge:
  - `o_wb_ack`=0, `o_wb_dat`=0, `o_tx_valid`=0, `o_irq`=0, `o_rx_ready`=0.
  - FIFOs empty, sticky flags 0, irq_en 0, SCRATCH 0.
  - `o_rx_ready` rises the first cycle `rst` is low.
- Reset mid-transaction: pending ack suppressed, in-flight data lost. The master must reissue.

## Test plan
- Write 0x12345678..0x1234567F to DATA with `i_tx_ready`=1 -> 8 stream beats in order, each one cycle after its ack; STATUS tx_level ends 0.
- `i_tx_ready`=0, 17 writes with DEPTH=16 -> first 16 stored; 17th dropped; STATUS = tx_full, tx_overflow, tx_level=0x10. Raise ready -> 16 beats, first = first written.
- Stream pushes 0xA0..0xA3 with irq_en=1 -> `o_irq` high 2 cycles after first push. Four DATA reads return 0xA0..0xA3. A fifth read returns 0 and sets rx_underflow. `o_irq` low after the 4th pop.
- Full TX with WB write and `i_tx_ready` pop in the same cycle -> write accepted, no overflow, level stays 16.
- CONTROL write 0x7 while both FIFOs are non-empty and a stream push happens the same cycle -> both FIFOs empty, flags 0; SCRATCH write/read 0xDEADBEEF returns unchanged.
- Assert `rst` mid-burst with the TX FIFO at 5 entries -> all outputs 0 next cycle, levels 0, `o_rx_ready` 1 the first cycle after release.
